// File: rtl/nanorv32_periph_arb.sv
// Two-master round-robin arbiter for the nanorv32 peripheral bus.
// One transfer at a time; transfers that see no ready within TIMEOUT cycles are aborted with err.
module nanorv32_periph_arb #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_bytesel,
  input  logic [31:0]       m0_din,
  output logic              m0_ack,
  output logic [31:0]       m0_dout,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_bytesel,
  input  logic [31:0]       m1_din,
  output logic              m1_ack,
  output logic [31:0]       m1_dout,
  output logic              m1_err,
  output logic [ADDR_W-1:0] bus_periph_addr,
  output logic [3:0]        bus_periph_bytesel,
  output logic [31:0]       bus_periph_din,
  output logic              bus_periph_en,
  input  logic [31:0]       periph_bus_dout,
  input  logic              periph_bus_ready
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic             owner;
  logic             last_owner;
  logic [CNT_W-1:0] cnt;

  logic             grant_m1_c;
  logic             done_c;
  logic [31:0]      resp_dout_c;
  logic             resp_err_c;

  // m1 wins when it is alone, or when both request and m0 was served last
  always_comb begin
    grant_m1_c  = m1_req & (~m0_req | ~last_owner);
    done_c      = periph_bus_ready | (cnt == CNT_LAST);
    resp_dout_c = periph_bus_ready ? periph_bus_dout : 32'd0;
    resp_err_c  = ~periph_bus_ready;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      owner              <= 1'b0;
      last_owner         <= 1'b1;
      cnt                <= '0;
      m0_ack             <= 1'b0;
      m0_dout            <= '0;
      m0_err             <= 1'b0;
      m1_ack             <= 1'b0;
      m1_dout            <= '0;
      m1_err             <= 1'b0;
      bus_periph_addr    <= '0;
      bus_periph_bytesel <= '0;
      bus_periph_din     <= '0;
      bus_periph_en      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner              <= grant_m1_c;
            bus_periph_addr    <= grant_m1_c ? m1_addr    : m0_addr;
            bus_periph_bytesel <= grant_m1_c ? m1_bytesel : m0_bytesel;
            bus_periph_din     <= grant_m1_c ? m1_din     : m0_din;
            cnt                <= '0;
            bus_periph_en      <= 1'b1;
            state              <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          // ready on the last allowed cycle still counts as success
          if (done_c) begin
            bus_periph_en <= 1'b0;
            state         <= RESP;
            if (owner) begin
              m1_ack  <= 1'b1;
              m1_dout <= resp_dout_c;
              m1_err  <= resp_err_c;
            end else begin
              m0_ack  <= 1'b1;
              m0_dout <= resp_dout_c;
              m0_err  <= resp_err_c;
            end
          end
        end
        RESP: begin
          m0_ack     <= 1'b0;
          m0_dout    <= '0;
          m0_err     <= 1'b0;
          m1_ack     <= 1'b0;
          m1_dout    <= '0;
          m1_err     <= 1'b0;
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nanorv32_periph_arb.sv
// Directed self-checking bench for nanorv32_periph_arb.
module tb_nanorv32_periph_arb;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic [3:0]  m0_bytesel, m1_bytesel;
  logic [31:0] m0_din, m1_din;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_dout, m1_dout;
  logic [31:0] bus_periph_addr, bus_periph_din;
  logic [3:0]  bus_periph_bytesel;
  logic        bus_periph_en;
  logic [31:0] periph_bus_dout;
  logic        periph_bus_ready;

  int checks = 0;
  int errors = 0;
  int n_en;

  always #5 clk_in = ~clk_in;

  nanorv32_periph_arb #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_bytesel(m0_bytesel), .m0_din(m0_din),
    .m0_ack(m0_ack), .m0_dout(m0_dout), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_bytesel(m1_bytesel), .m1_din(m1_din),
    .m1_ack(m1_ack), .m1_dout(m1_dout), .m1_err(m1_err),
    .bus_periph_addr(bus_periph_addr), .bus_periph_bytesel(bus_periph_bytesel),
    .bus_periph_din(bus_periph_din), .bus_periph_en(bus_periph_en),
    .periph_bus_dout(periph_bus_dout), .periph_bus_ready(periph_bus_ready)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0;
    m0_bytesel = 4'h0; m1_bytesel = 4'h0;
    m0_din = 32'h0; m1_din = 32'h0;
    periph_bus_dout = 32'h0; periph_bus_ready = 1'b0;

    // reset state
    tick();
    chk("rst_en", 32'(bus_periph_en), 0);
    chk("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 0);
    chk("rst_addr", bus_periph_addr, 0);
    rst_n = 1'b1;
    tick();

    // contention from reset: m0, m1, m0, m1, acks 3 cycles apart
    m0_req = 1'b1; m0_addr = 32'h100;
    m1_req = 1'b1; m1_addr = 32'h200;
    periph_bus_ready = 1'b1; periph_bus_dout = 32'h0BAD_0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_en", 32'(bus_periph_en), 1);
      chk("cont_addr", bus_periph_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      tick();
      chk("cont_ack", 32'({m0_ack, m1_ack}), (i % 2 == 0) ? 32'd2 : 32'd1);
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0; periph_bus_ready = 1'b0;
    tick();
    chk("cont_idle", 32'({bus_periph_en, m0_ack, m1_ack}), 0);

    // single read on m0
    m0_req = 1'b1; m0_addr = 32'h10; m0_bytesel = 4'h0;
    tick();
    chk("rd_en", 32'(bus_periph_en), 1);
    chk("rd_addr", bus_periph_addr, 32'h10);
    periph_bus_ready = 1'b1; periph_bus_dout = 32'hCAFEF00D;
    tick();
    chk("rd_en_low", 32'(bus_periph_en), 0);
    chk("rd_ack", 32'({m0_ack, m0_err, m1_ack}), 32'd4);
    chk("rd_dout", m0_dout, 32'hCAFEF00D);
    m0_req = 1'b0; periph_bus_ready = 1'b0;
    tick();
    chk("rd_ack_once", 32'({m0_ack, bus_periph_en}), 0);

    // m1 write with wait states, ready in third en cycle
    m1_req = 1'b1; m1_addr = 32'h40; m1_bytesel = 4'b1100; m1_din = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_en", 32'(bus_periph_en), 1);
      chk("wr_bytesel", 32'(bus_periph_bytesel), 32'hC);
      chk("wr_din", bus_periph_din, 32'h12345678);
    end
    periph_bus_ready = 1'b1; periph_bus_dout = 32'h0000A5A5;
    tick();
    chk("wr_ack", 32'({m1_ack, m1_err, m0_ack, bus_periph_en}), 32'd8);
    chk("wr_dout", m1_dout, 32'h0000A5A5);
    m1_req = 1'b0; periph_bus_ready = 1'b0;
    tick();

    // timeout: en high exactly 16 cycles then ack+err
    m0_req = 1'b1; m0_addr = 32'h20; periph_bus_dout = 32'hFFFF_FFFF;
    n_en = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus_periph_en) n_en++;
      if (m0_ack) break;
    end
    chk("to_en_cycles", 32'(n_en), 16);
    chk("to_ack_err", 32'({m0_ack, m0_err, m1_ack}), 32'd6);
    chk("to_dout", m0_dout, 0);
    m0_req = 1'b0;
    tick();

    // ready on the 16th en cycle is success
    m0_req = 1'b1; periph_bus_dout = 32'h0000_1616;
    for (int k = 0; k < 16; k++) tick();
    chk("to16_en", 32'(bus_periph_en), 1);
    periph_bus_ready = 1'b1;
    tick();
    chk("to16_ack", 32'({m0_ack, m0_err}), 32'd2);
    chk("to16_dout", m0_dout, 32'h0000_1616);
    m0_req = 1'b0; periph_bus_ready = 1'b0;
    tick();

    // reset during second en cycle of an m1 transfer
    m1_req = 1'b1; m1_addr = 32'h300;
    tick();
    tick();
    chk("mr_en", 32'(bus_periph_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async_en", 32'(bus_periph_en), 0);
    chk("mr_async_addr", bus_periph_addr, 0);
    m0_req = 1'b1; m0_addr = 32'h400;
    tick();
    chk("mr_no_ack", 32'({m0_ack, m1_ack}), 0);
    rst_n = 1'b1;
    tick();
    chk("mr_grant_m0", bus_periph_addr, 32'h400);
    chk("mr_en2", 32'(bus_periph_en), 1);
    periph_bus_ready = 1'b1;
    tick();
    chk("mr_ack_m0", 32'({m0_ack, m1_ack}), 32'd2);
    m0_req = 1'b0; m1_req = 1'b0; periph_bus_ready = 1'b0;
    tick();

    // stray ready in IDLE and RESP
    periph_bus_ready = 1'b1;
    tick();
    tick();
    chk("stray_idle", 32'({bus_periph_en, m0_ack, m1_ack}), 0);
    periph_bus_ready = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h500;
    tick();
    periph_bus_ready = 1'b1;
    tick();
    chk("stray_ack", 32'(m1_ack), 1);
    m1_req = 1'b0;
    tick();
    chk("stray_resp", 32'({bus_periph_en, m0_ack, m1_ack}), 0);
    tick();
    chk("stray_resp2", 32'({bus_periph_en, m0_ack, m1_ack}), 0);
    periph_bus_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
